memory_turn_scoreboard: RTL and testbench
=========================================

Name: memory_turn_scoreboard

Overview:
- Parametrised turn, timer and score engine for the N-player memory card game. It generalises the fixed two-player pair counter and the free-running seconds timer.
- Consumes match/miss pulses from the game FSM and runs a per-turn countdown. Rotates the active player, keeps per-player pair scores and declares the winner.
- Feeds the seven-segment decoders (BCD time) and the VGA layer (current player, game over). All logic runs in the VGA clock domain.

Parameters:
- N_PLAYERS, 2, number of players (2..8); PW = $clog2(N_PLAYERS), minimum 1.
- PAIRS_TOTAL, 8, total pairs on the board; SW = $clog2(PAIRS_TOTAL+1).
- TURN_SECONDS, 15, seconds per turn (1..99).
- CLK_HZ, 25_000_000, clk frequency; one second = CLK_HZ cycles.

Ports:
- clk  in  1  system clock (vga_clk)
- rst  in  1  asynchronous reset, active-low
- start  in  1  level; sampled in IDLE/OVER to begin a new game
- pause  in  1  level; freezes the countdown while high in PLAY
- pair_found  in  1  one-cycle pulse: current player matched a pair
- pair_miss  in  1  one-cycle pulse: current player flipped a non-matching pair
- current_player  out  PW  index of the active player
- scores  out  N_PLAYERS*SW  packed scores; player i at [i*SW +: SW]
- time_left_bcd  out  8  remaining turn seconds, {tens, units} BCD
- sec_tick  out  1  one-cycle pulse per elapsed second in PLAY
- turn_timeout  out  1  one-cycle pulse when a turn expires
- game_over  out  1  high in OVER
- winner  out  PW  highest score; lowest index on a tie
- tie  out  1  high in OVER when more than one player holds the max score

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0, except time_left_bcd = BCD(TURN_SECONDS). Prescaler 0.
- All outputs are registered. The effect of an input is visible on the cycle after it is sampled.
- IDLE -> PLAY on start=1:
  - clear scores and pairs_left = PAIRS_TOTAL;
  - set current_player = 0 and time = TURN_SECONDS;
  - clear the prescaler.
- PLAY:
  - The prescaler counts 0..CLK_HZ-1. On wrap, sec_tick pulses and time decrements.
  - If time would reach 0 on a tick: turn_timeout pulses, the player advances, time reloads to TURN_SECONDS.
  - pair_found: score[current]+1, pairs_left-1, time reloads, prescaler clears. The same player keeps the turn.
  - pair_miss: player advances, time reloads, prescaler clears.
  - Player advance: (current_player+1) mod N_PLAYERS. Player N_PLAYERS-1 wraps to 0.
  - pause=1 holds the prescaler and time. Events are still accepted while paused.
- PLAY -> OVER when pair_found takes pairs_left to 0. In that cycle:
  - latch winner and tie;
  - hold the final score, current_player and time;
  - do not reload the timer.
- OVER -> PLAY on start=1, with the same initialisation as IDLE -> PLAY.
- Priority within one cycle: pair_found > pair_miss > timeout tick.
  - pair_found with pair_miss: treat as found only.
  - Any event together with the expiring tick: the event wins, with no turn_timeout and no double advance.
- start is ignored in PLAY. pair_found and pair_miss are ignored in IDLE and OVER.
- The score cannot exceed PAIRS_TOTAL by construction. No saturation logic is needed; the bench asserts this bound.
- BCD: tens = time/10, units = time%10. time_left_bcd is registered alongside time.

Decomposition:
- Shared package memgame_pkg:
  - state enum {IDLE, PLAY, OVER};
  - function to_bcd2(int) returning 8-bit BCD;
  - the default TURN_SECONDS and PAIRS_TOTAL constants.
- One sub-module, sec_prescaler (params CLK_HZ):
  - inputs: clk, rst, en, clr;
  - output: tick.
- Winner/tie: a combinational max-scan loop over scores, registered on entry to OVER.

Test Plan:
- Bench parameters for all cases: N_PLAYERS=3, PAIRS_TOTAL=4, TURN_SECONDS=3, CLK_HZ=10.
- Reset mid-game:
  - Stimulus: start; found one pair; drop rst for 2 cycles.
  - Required response: scores=0, current_player=0, state IDLE, time_left_bcd=8'h03, game_over=0.
- Countdown and timeout:
  - Stimulus: start, then idle for 30 cycles.
  - Required response: sec_tick at cycles 10, 20 and 30; time 3->2->1; turn_timeout at cycle 30; current_player=1; time back to 8'h03.
- Match keeps turn, miss rotates with wrap:
  - Stimulus: pair_found, then pair_miss three times.
  - Required response: after the found, score[0]=1 and player 0; the misses give player 1, then 2, then 0.
- Simultaneous events:
  - Stimulus: pair_found and pair_miss in the same cycle. Separately, pair_miss in the cycle of the expiring tick.
  - Required response: the first gives score+1 with no advance. The second gives exactly one advance and no turn_timeout.
- Pause:
  - Stimulus: hold pause for 50 cycles mid-turn.
  - Required response: no sec_tick, time unchanged. The countdown resumes from the held prescaler value.
- Game over with tie and restart:
  - Stimulus: P0 finds 2 pairs, a miss, P1 finds 2 pairs.
  - Required response: game_over=1, winner=0, tie=1, scores={0,2,2}.
  - Then start: new game, scores cleared, current_player=0.

Source files
------------

// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory card game scoreboard.
package memgame_pkg;

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    localparam int unsigned DefaultTurnSeconds = 15;
    localparam int unsigned DefaultPairsTotal  = 8;

    // Two-digit packed BCD, {tens, units}; callers keep value below 100.
    function automatic logic [7:0] to_bcd2(input int value);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(value / 10);
        units = 4'(value % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts enabled cycles 0..ClkHz-1, tick flags the wrap cycle.
module sec_prescaler #(
    parameter int unsigned ClkHz = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (ClkHz > 1) ? $clog2(ClkHz) : 1;

    logic [CW-1:0] count_q;

    assign tick = en & (count_q == CW'(ClkHz - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/memory_turn_scoreboard.sv
// Turn rotation, per-turn countdown and pair scoring for the N-player memory game.
module memory_turn_scoreboard
    import memgame_pkg::*;
#(
    parameter int unsigned NPlayers    = 2,
    parameter int unsigned PairsTotal  = DefaultPairsTotal,
    parameter int unsigned TurnSeconds = DefaultTurnSeconds,
    parameter int unsigned ClkHz       = 25_000_000,
    localparam int unsigned PW = (NPlayers > 1) ? $clog2(NPlayers) : 1,
    localparam int unsigned SW = $clog2(PairsTotal + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     pair_found,
    input  logic                     pair_miss,
    output logic [PW-1:0]            current_player,
    output logic [NPlayers*SW-1:0]   scores,
    output logic [7:0]               time_left_bcd,
    output logic                     sec_tick,
    output logic                     turn_timeout,
    output logic                     game_over,
    output logic [PW-1:0]            winner,
    output logic                     tie
);

    localparam logic [6:0]    TimeInit   = 7'(TurnSeconds);
    localparam logic [PW-1:0] LastPlayer = PW'(NPlayers - 1);
    localparam logic [SW-1:0] PairsInit  = SW'(PairsTotal);

    state_e        state_q;
    logic [PW-1:0] player_q, player_d, winner_q, best_idx;
    logic [SW-1:0] score_q [NPlayers];
    logic [SW-1:0] score_d [NPlayers];
    logic [SW-1:0] pairs_left_q, best_score;
    logic [6:0]    time_q, time_d;
    logic [7:0]    bcd_q;
    logic          sec_tick_q, timeout_q, game_over_q, tie_q, best_tie;
    logic          playing, begin_game, found, miss, tick, expire, game_end;

    assign playing    = (state_q == StPlay);
    assign begin_game = start & ~playing;
    assign found      = playing & pair_found;
    assign miss       = playing & pair_miss & ~pair_found;
    // A tick on the last second only times out when no player event claims the cycle.
    assign expire     = playing & tick & ~pair_found & ~pair_miss & (time_q == 7'd1);
    assign game_end   = found & (pairs_left_q == SW'(1));

    sec_prescaler #(
        .ClkHz (ClkHz)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (playing & ~pause),
        .clr  (begin_game | found | miss),
        .tick (tick)
    );

    always_comb begin
        player_d = player_q;
        if (begin_game) begin
            player_d = '0;
        end else if (miss || expire) begin
            player_d = (player_q == LastPlayer) ? '0 : player_q + PW'(1);
        end
    end

    always_comb begin
        time_d = time_q;
        if (begin_game) begin
            time_d = TimeInit;
        end else if (found) begin
            time_d = game_end ? time_q : TimeInit;
        end else if (miss || expire) begin
            time_d = TimeInit;
        end else if (playing && tick) begin
            time_d = time_q - 7'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NPlayers; i++) begin
            score_d[i] = score_q[i];
            if (found && player_q == PW'(i)) begin
                score_d[i] = score_q[i] + SW'(1);
            end
        end
    end

    // Scan the post-increment scores so the final pair counts toward the verdict.
    always_comb begin
        best_idx   = '0;
        best_score = score_d[0];
        best_tie   = 1'b0;
        for (int i = 1; i < NPlayers; i++) begin
            if (score_d[i] > best_score) begin
                best_idx   = PW'(i);
                best_score = score_d[i];
                best_tie   = 1'b0;
            end else if (score_d[i] == best_score) begin
                best_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            player_q     <= '0;
            pairs_left_q <= '0;
            time_q       <= TimeInit;
            bcd_q        <= to_bcd2(int'(TurnSeconds));
            sec_tick_q   <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= '0;
            tie_q        <= 1'b0;
            for (int i = 0; i < NPlayers; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            sec_tick_q <= tick;
            timeout_q  <= expire;
            player_q   <= player_d;
            time_q     <= time_d;
            bcd_q      <= to_bcd2(int'(time_d));
            case (state_q)
                StPlay: begin
                    for (int i = 0; i < NPlayers; i++) begin
                        score_q[i] <= score_d[i];
                    end
                    if (found) begin
                        pairs_left_q <= pairs_left_q - SW'(1);
                    end
                    if (game_end) begin
                        state_q     <= StOver;
                        game_over_q <= 1'b1;
                        winner_q    <= best_idx;
                        tie_q       <= best_tie;
                    end
                end
                default: begin
                    if (start) begin
                        state_q      <= StPlay;
                        pairs_left_q <= PairsInit;
                        game_over_q  <= 1'b0;
                        winner_q     <= '0;
                        tie_q        <= 1'b0;
                        for (int i = 0; i < NPlayers; i++) begin
                            score_q[i] <= '0;
                        end
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NPlayers; g++) begin : g_scores
        assign scores[g*SW +: SW] = score_q[g];
    end

    assign current_player = player_q;
    assign time_left_bcd  = bcd_q;
    assign sec_tick       = sec_tick_q;
    assign turn_timeout   = timeout_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;
    assign tie            = tie_q;

endmodule

// File: tb/tb_memory_turn_scoreboard.sv
// Randomized and directed bench for memory_turn_scoreboard against a game-rules model.
module tb_memory_turn_scoreboard;

    localparam int NP   = 3;
    localparam int PT   = 4;
    localparam int TS   = 3;
    localparam int HZ   = 10;
    localparam int PWB  = 2;
    localparam int SWB  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, pause, pair_found, pair_miss;
    logic [PWB-1:0]   current_player, winner;
    logic [NP*SWB-1:0] scores;
    logic [7:0]       time_left_bcd;
    logic             sec_tick, turn_timeout, game_over, tie;

    int total = 0;
    int bad   = 0;

    // Game-rules model; state 0 = idle, 1 = playing, 2 = over.
    int m_state, m_player, m_pairs, m_time, m_presc, m_winner;
    int m_scores [NP];
    bit m_tie, m_tick, m_to;

    memory_turn_scoreboard #(
        .NPlayers    (NP),
        .PairsTotal  (PT),
        .TurnSeconds (TS),
        .ClkHz       (HZ)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pause          (pause),
        .pair_found     (pair_found),
        .pair_miss      (pair_miss),
        .current_player (current_player),
        .scores         (scores),
        .time_left_bcd  (time_left_bcd),
        .sec_tick       (sec_tick),
        .turn_timeout   (turn_timeout),
        .game_over      (game_over),
        .winner         (winner),
        .tie            (tie)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_player = 0; m_pairs = 0; m_time = TS; m_presc = 0;
        m_winner = 0; m_tie = 0; m_tick = 0; m_to = 0;
        for (int i = 0; i < NP; i++) m_scores[i] = 0;
    endtask

    task automatic model_new_game();
        m_state = 1; m_player = 0; m_pairs = PT; m_time = TS; m_presc = 0;
        m_winner = 0; m_tie = 0;
        for (int i = 0; i < NP; i++) m_scores[i] = 0;
    endtask

    task automatic model_verdict();
        int best, cnt;
        best = -1; cnt = 0;
        for (int i = 0; i < NP; i++) if (m_scores[i] > best) best = m_scores[i];
        for (int i = NP - 1; i >= 0; i--) begin
            if (m_scores[i] == best) begin
                cnt++;
                m_winner = i;
            end
        end
        m_tie = (cnt > 1);
    endtask

    task automatic model_step(input bit st, input bit pa, input bit pf, input bit pm);
        bit tk;
        m_tick = 0; m_to = 0;
        if (m_state == 1) begin
            tk = !pa && (m_presc == HZ - 1);
            m_tick = tk;
            if (pf || pm) m_presc = 0;
            else if (!pa) m_presc = (m_presc + 1) % HZ;
            if (pf) begin
                m_scores[m_player] += 1;
                m_pairs -= 1;
                if (m_pairs == 0) begin
                    m_state = 2;
                    model_verdict();
                end else begin
                    m_time = TS;
                end
            end else if (pm) begin
                m_player = (m_player + 1) % NP;
                m_time = TS;
            end else if (tk) begin
                if (m_time == 1) begin
                    m_to = 1;
                    m_player = (m_player + 1) % NP;
                    m_time = TS;
                end else begin
                    m_time -= 1;
                end
            end
        end else if (st) begin
            model_new_game();
        end
    endtask

    function automatic logic [NP*SWB-1:0] exp_scores();
        logic [NP*SWB-1:0] v;
        for (int i = 0; i < NP; i++) v[i*SWB +: SWB] = SWB'(m_scores[i]);
        return v;
    endfunction

    task automatic compare_all();
        check_eq("player", 32'(current_player), m_player);
        check_eq("scores", 32'(scores), 32'(exp_scores()));
        check_eq("time_bcd", 32'(time_left_bcd), (m_time / 10) * 16 + m_time % 10);
        check_eq("sec_tick", 32'(sec_tick), 32'(m_tick));
        check_eq("turn_timeout", 32'(turn_timeout), 32'(m_to));
        check_eq("game_over", 32'(game_over), 32'(m_state == 2));
        check_eq("winner", 32'(winner), m_winner);
        check_eq("tie", 32'(tie), 32'(m_tie));
        for (int i = 0; i < NP; i++) begin
            check_eq("score_bound", 32'(scores[i*SWB +: SWB] <= PT), 1);
        end
    endtask

    task automatic step(input bit st, input bit pa, input bit pf, input bit pm);
        start = st; pause = pa; pair_found = pf; pair_miss = pm;
        @(posedge clk);
        model_step(st, pa, pf, pm);
        #1;
        start = 0; pause = 0; pair_found = 0; pair_miss = 0;
        compare_all();
    endtask

    // Asynchronous assertion between clock edges, held for the given edge count.
    task automatic do_reset(input int cycles);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (cycles) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        int ticks_seen;
        rst = 1'b0; start = 0; pause = 0; pair_found = 0; pair_miss = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check_eq("reset_bcd", 32'(time_left_bcd), 32'h03);
        rst = 1'b1;

        // Reset mid-game.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check_eq("pre_reset_score", 32'(scores[2:0]), 1);
        do_reset(2);
        check_eq("rst_scores", 32'(scores), 0);
        check_eq("rst_player", 32'(current_player), 0);
        check_eq("rst_bcd", 32'(time_left_bcd), 32'h03);
        check_eq("rst_over", 32'(game_over), 0);

        // Countdown and timeout.
        step(1, 0, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0, 0);
            if (k == 10) check_eq("tick10_bcd", 32'(time_left_bcd), 32'h02);
            if (k == 20) check_eq("tick20_bcd", 32'(time_left_bcd), 32'h01);
            if (k == 9) check_eq("no_tick9", 32'(sec_tick), 0);
        end
        check_eq("to_pulse", 32'(turn_timeout), 1);
        check_eq("to_player", 32'(current_player), 1);
        check_eq("to_bcd", 32'(time_left_bcd), 32'h03);

        // Match keeps turn, misses rotate with wrap.
        do_reset(1);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check_eq("found_score0", 32'(scores[2:0]), 1);
        check_eq("found_player", 32'(current_player), 0);
        step(0, 0, 0, 1);
        check_eq("miss1", 32'(current_player), 1);
        step(0, 0, 0, 1);
        check_eq("miss2", 32'(current_player), 2);
        step(0, 0, 0, 1);
        check_eq("miss3_wrap", 32'(current_player), 0);

        // Simultaneous events.
        step(0, 0, 1, 1);
        check_eq("both_score0", 32'(scores[2:0]), 2);
        check_eq("both_player", 32'(current_player), 0);
        repeat (29) step(0, 0, 0, 0);
        check_eq("pre_expire_bcd", 32'(time_left_bcd), 32'h01);
        step(0, 0, 0, 1);
        check_eq("miss_expire_player", 32'(current_player), 1);
        check_eq("miss_expire_to", 32'(turn_timeout), 0);
        check_eq("miss_expire_bcd", 32'(time_left_bcd), 32'h03);
        step(0, 0, 0, 0);
        check_eq("miss_expire_after", 32'(current_player), 1);

        // Pause mid-turn.
        repeat (4) step(0, 0, 0, 0);
        ticks_seen = 0;
        for (int k = 0; k < 50; k++) begin
            step(0, 1, 0, 0);
            if (sec_tick) ticks_seen++;
        end
        check_eq("pause_ticks", ticks_seen, 0);
        check_eq("pause_bcd", 32'(time_left_bcd), 32'h03);
        repeat (4) step(0, 0, 0, 0);
        check_eq("resume_no_tick", 32'(sec_tick), 0);
        step(0, 0, 0, 0);
        check_eq("resume_tick", 32'(sec_tick), 1);
        check_eq("resume_bcd", 32'(time_left_bcd), 32'h02);

        // Game over with a tie, then restart.
        do_reset(1);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check_eq("over_flag", 32'(game_over), 1);
        check_eq("over_winner", 32'(winner), 0);
        check_eq("over_tie", 32'(tie), 1);
        check_eq("over_scores", 32'(scores), 32'h012);
        step(0, 0, 1, 1);
        check_eq("over_ignores", 32'(scores), 32'h012);
        step(1, 0, 0, 0);
        check_eq("restart_scores", 32'(scores), 0);
        check_eq("restart_player", 32'(current_player), 0);
        check_eq("restart_over", 32'(game_over), 0);

        // Randomized play.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
                     $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
